// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter: single-port memory arbiter that services either a matrix
// load (ROWS rows of two words each, read from consecutive addresses) or a
// single row store (two words), one operation at a time.
//
// Ports:
//   CLK, nRST           clock, asynchronous active-low reset
//   sLoad, load_addr    matrix-load request and base byte address
//   sStore, store_addr, store_data
//                       row-store request, byte address and row data
//   load_data           fetched row {word@addr+4, word@addr}
//   sLoad_hit/sLoad_row one-cycle pulse per fetched row, with row index
//   sStore_hit          one-cycle pulse when the store has completed
//   mem_*               word-wide memory port; a word transfers in any cycle
//                       with (mem_ren|mem_wen) && mem_ready
//
// Build option: define SP_ARB_LOAD_FIRST_EN to give sLoad priority over
// sStore when both are requested in IDLE (default: sStore wins).
module sp_mem_arbiter #(
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned ROW_S_W      = 2,
  parameter int unsigned BITS_PER_ROW = 64,
  parameter int unsigned ROWS         = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    sLoad,
  input  logic                    sStore,
  input  logic [WORD_W-1:0]       load_addr,
  input  logic [WORD_W-1:0]       store_addr,
  input  logic [BITS_PER_ROW-1:0] store_data,
  output logic [BITS_PER_ROW-1:0] load_data,
  output logic                    sLoad_hit,
  output logic [ROW_S_W-1:0]      sLoad_row,
  output logic                    sStore_hit,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [WORD_W-1:0]       mem_addr,
  output logic [WORD_W-1:0]       mem_wdata,
  input  logic [WORD_W-1:0]       mem_rdata,
  input  logic                    mem_ready
);

  localparam int unsigned CNT_W = (ROWS * 2 > 1) ? $clog2(ROWS * 2) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(ROWS * 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        word_q, word_d;
  logic [WORD_W-1:0]       addr_q, addr_d;
  logic [BITS_PER_ROW-1:0] sdata_q, sdata_d;
  logic [WORD_W-1:0]       lo_q, lo_d;
  logic [BITS_PER_ROW-1:0] ldata_q, ldata_d;
  logic                    lhit_q, lhit_d;
  logic [ROW_S_W-1:0]      row_q, row_d;
  logic                    shit_q, shit_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      lo_q    <= '0;
      ldata_q <= '0;
      lhit_q  <= 1'b0;
      row_q   <= '0;
      shit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      lo_q    <= lo_d;
      ldata_q <= ldata_d;
      lhit_q  <= lhit_d;
      row_q   <= row_d;
      shit_q  <= shit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    lo_d      = lo_q;
    ldata_d   = ldata_q;
    row_d     = row_q;
    lhit_d    = 1'b0;
    shit_d    = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        word_d = '0;
`ifdef SP_ARB_LOAD_FIRST_EN
        if (sLoad) begin
          addr_d  = load_addr;
          state_d = LOAD;
        end else if (sStore) begin
          addr_d  = store_addr;
          sdata_d = store_data;
          state_d = STORE;
        end
`else
        if (sStore) begin
          addr_d  = store_addr;
          sdata_d = store_data;
          state_d = STORE;
        end else if (sLoad) begin
          addr_d  = load_addr;
          state_d = LOAD;
        end
`endif
      end

      LOAD: begin
        mem_ren  = 1'b1;
        mem_addr = addr_q;
        if (mem_ready) begin
          addr_d = addr_q + WORD_W'(4);
          word_d = word_q + CNT_W'(1);
          // Even words are parked until their odd partner arrives, so the
          // row and its hit are registered together the following cycle.
          if (!word_q[0]) begin
            lo_d = mem_rdata;
          end else begin
            ldata_d = {mem_rdata, lo_q};
            lhit_d  = 1'b1;
            row_d   = ROW_S_W'(word_q >> 1);
          end
          if (word_q == LAST_WORD) state_d = DONE;
        end
      end

      STORE: begin
        mem_wen   = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = word_q[0] ? sdata_q[2*WORD_W-1:WORD_W] : sdata_q[WORD_W-1:0];
        if (mem_ready) begin
          addr_d = addr_q + WORD_W'(4);
          word_d = word_q + CNT_W'(1);
          if (word_q[0]) begin
            shit_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        word_d  = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign load_data  = ldata_q;
  assign sLoad_hit  = lhit_q;
  assign sLoad_row  = row_q;
  assign sStore_hit = shit_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
module tb_sp_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        sLoad, sStore;
  logic [31:0] load_addr, store_addr;
  logic [63:0] store_data;
  logic [63:0] load_data;
  logic        sLoad_hit;
  logic [1:0]  sLoad_row;
  logic        sStore_hit;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_from = -10;

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } mem_t;
  typedef struct { bit st; int row; logic [63:0] data; int cyc; } hit_t;

  mem_t rd_q[$];
  mem_t wr_q[$];
  hit_t hit_q[$];
  mem_t me;
  hit_t he;

  sp_mem_arbiter #(.WORD_W(32), .ROW_S_W(2), .BITS_PER_ROW(64), .ROWS(4)) dut (
    .CLK(CLK), .nRST(nRST), .sLoad(sLoad), .sStore(sStore),
    .load_addr(load_addr), .store_addr(store_addr), .store_data(store_data),
    .load_data(load_data), .sLoad_hit(sLoad_hit), .sLoad_row(sLoad_row),
    .sStore_hit(sStore_hit), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory contents as a pure function of address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction
  assign mem_rdata = memf(mem_addr);

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_load(input int t0, input logic [31:0] base, input int extra, input int nwords);
    for (int k = 0; k < nwords; k++)
      rd_q.push_back('{base + 32'(4 * k), memf(base + 32'(4 * k)), t0 + 1 + k + ((k >= 1) ? extra : 0)});
    for (int r = 0; 2 * r + 1 < nwords; r++)
      hit_q.push_back('{1'b0, r, {memf(base + 32'(8 * r + 4)), memf(base + 32'(8 * r))}, t0 + 3 + 2 * r + extra});
  endtask

  task automatic push_store(input int t0, input logic [31:0] a, input logic [63:0] d);
    wr_q.push_back('{a, d[31:0], t0 + 1});
    wr_q.push_back('{a + 32'd4, d[63:32], t0 + 2});
    hit_q.push_back('{1'b1, 0, 64'h0, t0 + 3});
  endtask

  task automatic start_load(input logic [31:0] base, input int extra, input int nwords);
    int t0;
    @(negedge CLK);
    sLoad = 1'b1;
    load_addr = base;
    t0 = cyc;
    if (extra > 0) stall_from = t0 + 2;
    push_load(t0, base, extra, nwords);
    @(negedge CLK);
    sLoad = 1'b0;
  endtask

  task automatic start_store(input logic [31:0] a, input logic [63:0] d);
    int t0;
    @(negedge CLK);
    sStore = 1'b1;
    store_addr = a;
    store_data = d;
    t0 = cyc;
    push_store(t0, a, d);
    @(negedge CLK);
    sStore = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 100 && (rd_q.size() + wr_q.size() + hit_q.size()) != 0; i++)
      @(negedge CLK);
    chk((rd_q.size() + wr_q.size() + hit_q.size()) == 0, nm,
        64'(rd_q.size() + wr_q.size() + hit_q.size()), 64'h0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic out_zero(input string nm);
    chk(load_data == 64'h0, {nm, "_load_data"}, load_data, 64'h0);
    chk(sLoad_hit == 1'b0, {nm, "_sLoad_hit"}, 64'(sLoad_hit), 64'h0);
    chk(sLoad_row == 2'd0, {nm, "_sLoad_row"}, 64'(sLoad_row), 64'h0);
    chk(sStore_hit == 1'b0, {nm, "_sStore_hit"}, 64'(sStore_hit), 64'h0);
    chk(mem_ren == 1'b0, {nm, "_mem_ren"}, 64'(mem_ren), 64'h0);
    chk(mem_wen == 1'b0, {nm, "_mem_wen"}, 64'(mem_wen), 64'h0);
    chk(mem_addr == 32'h0, {nm, "_mem_addr"}, 64'(mem_addr), 64'h0);
    chk(mem_wdata == 32'h0, {nm, "_mem_wdata"}, 64'(mem_wdata), 64'h0);
  endtask

  // Monitor: drives this cycle's mem_ready, then checks whatever the DUT presents.
  always @(negedge CLK) begin
    mem_ready = !(cyc >= stall_from && cyc < stall_from + 3);
    if (nRST === 1'b1) begin
      chk(!(mem_ren && mem_wen) && !(sLoad_hit && sStore_hit), "exclusive",
          64'({mem_ren, mem_wen, sLoad_hit, sStore_hit}), 64'h0);
      if (mem_ren) begin
        if (rd_q.size() == 0) begin
          chk(1'b0, "rd_unexpected", 64'(mem_addr), 64'h0);
        end else if (mem_ready) begin
          me = rd_q.pop_front();
          chk(mem_addr == me.addr, "rd_addr", 64'(mem_addr), 64'(me.addr));
          chk(cyc == me.cyc, "rd_cycle", 64'(cyc), 64'(me.cyc));
        end else begin
          chk(mem_addr == rd_q[0].addr, "rd_addr_hold", 64'(mem_addr), 64'(rd_q[0].addr));
        end
      end
      if (mem_wen && mem_ready) begin
        if (wr_q.size() == 0) begin
          chk(1'b0, "wr_unexpected", 64'(mem_addr), 64'h0);
        end else begin
          me = wr_q.pop_front();
          chk(mem_addr == me.addr, "wr_addr", 64'(mem_addr), 64'(me.addr));
          chk(mem_wdata == me.data, "wr_data", 64'(mem_wdata), 64'(me.data));
          chk(cyc == me.cyc, "wr_cycle", 64'(cyc), 64'(me.cyc));
        end
      end
      if (sLoad_hit || sStore_hit) begin
        if (hit_q.size() == 0) begin
          chk(1'b0, "hit_unexpected", 64'({sLoad_hit, sStore_hit}), 64'h0);
        end else begin
          he = hit_q.pop_front();
          chk(sStore_hit == he.st, "hit_kind", 64'(sStore_hit), 64'(he.st));
          chk(cyc == he.cyc, "hit_cycle", 64'(cyc), 64'(he.cyc));
          if (!he.st) begin
            chk(sLoad_row == 2'(he.row), "hit_row", 64'(sLoad_row), 64'(he.row));
            chk(load_data == he.data, "hit_data", load_data, he.data);
          end
        end
      end
    end
  end

  initial begin
    int t0;
    nRST = 1'b0;
    sLoad = 1'b0;
    sStore = 1'b0;
    load_addr = '0;
    store_addr = '0;
    store_data = '0;
    repeat (3) @(negedge CLK);
    out_zero("reset");
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    start_load(32'h0000_0100, 0, 8);
    drain("load_basic");

    start_store(32'h0000_0200, 64'hAAAABBBB_CCCCDDDD);
    drain("store_basic");

    // Simultaneous requests: the loser is held until it gets accepted.
    @(negedge CLK);
    sLoad = 1'b1;
    sStore = 1'b1;
    load_addr = 32'h0000_0500;
    store_addr = 32'h0000_0600;
    store_data = 64'h1122_3344_5566_7788;
    t0 = cyc;
`ifdef SP_ARB_LOAD_FIRST_EN
    push_load(t0, 32'h0000_0500, 0, 8);
    push_store(t0 + 10, 32'h0000_0600, 64'h1122_3344_5566_7788);
    @(negedge CLK);
    sLoad = 1'b0;
    repeat (10) @(negedge CLK);
    sStore = 1'b0;
`else
    push_store(t0, 32'h0000_0600, 64'h1122_3344_5566_7788);
    push_load(t0 + 4, 32'h0000_0500, 0, 8);
    @(negedge CLK);
    sStore = 1'b0;
    repeat (4) @(negedge CLK);
    sLoad = 1'b0;
`endif
    drain("both_requests");

    start_load(32'h0000_0100, 3, 8);
    drain("load_wait_states");
    stall_from = -10;

    // Reset right after the row-1 hit; rows 2/3 must never appear.
    start_load(32'h0000_0300, 0, 5);
    repeat (4) @(negedge CLK);
    @(posedge CLK);
    #1 nRST = 1'b0;
    #1 out_zero("mid_reset");
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    drain("after_reset");

    start_load(32'h0000_0400, 0, 8);
    drain("load_post_reset");

    start_load(32'hFFFF_FFF0, 0, 8);
    drain("load_wrap");

    start_store(32'hFFFF_FFFC, 64'hDEADBEEF_0BADF00D);
    drain("store_wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sp_mem_arbiter.md
SP_MEM_ARBITER -- requirements
Module: sp_mem_arbiter

Interface
REQ-001 SHALL have parameters: WORD_W, default 32, word width; ROW_S_W, default 2, row-select width; BITS_PER_ROW, default 64, row width (2 words); ROWS, default 4, rows per matrix load.
REQ-002 SHALL have ports: CLK  in  1  clock; nRST  in  1  async active-low reset.
REQ-003 SHALL have ports: sLoad  in  1  matrix-load request; sStore  in  1  row-store request; load_addr  in  WORD_W  load base byte address; store_addr  in  WORD_W  store byte address; store_data  in  BITS_PER_ROW  row to store.
REQ-004 SHALL have ports: load_data  out  BITS_PER_ROW  fetched row; sLoad_hit  out  1  row-valid pulse; sLoad_row  out  ROW_S_W  row index of load_data; sStore_hit  out  1  store-done pulse.
REQ-005 SHALL have ports: mem_ren  out  1; mem_wen  out  1; mem_addr  out  WORD_W; mem_wdata  out  WORD_W; mem_rdata  in  WORD_W; mem_ready  in  1, word transfer completes in any cycle where mem_ren|mem_wen and mem_ready are both 1.
REQ-006 SHALL use one clock CLK; reset nRST is asynchronous and active-low.

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, STORE, DONE.
REQ-008 SHALL, in IDLE, accept a pending request at the clock edge, latch its address (and store_data), and enter LOAD or STORE; the request cycle issues no memory access.
REQ-009 SHALL, when sLoad and sStore are both 1 in IDLE, accept sStore (unless REQ-021).
REQ-010 SHALL, in LOAD, read ROWS*2 consecutive words; word k at latched load_addr + 4k; mem_ren=1 and mem_wen=0 throughout LOAD.
REQ-011 SHALL pack each row as {high word at higher address, low word at lower address} into load_data.
REQ-012 SHALL pulse sLoad_hit for exactly one cycle, registered, the cycle after the row's second word completes, with sLoad_row = row index 0..ROWS-1 and load_data stable in that cycle.
REQ-013 SHALL keep issuing the next row's reads during a row's sLoad_hit cycle (no bubble).
REQ-014 SHALL, in STORE, write store_data[31:0] to latched store_addr then store_data[63:32] to store_addr+4; mem_wen=1, mem_ren=0.
REQ-015 SHALL, after the last word of a load or store completes, enter DONE for exactly one cycle; the final sLoad_hit (row ROWS-1) or sStore_hit is asserted in DONE; DONE then returns to IDLE.
REQ-016 SHALL ignore sLoad/sStore in LOAD, STORE and DONE; requesters drop the request the cycle after the final hit.
REQ-017 SHALL hold mem_addr/mem_wdata stable while a word waits for mem_ready; wait states of any length are legal.
REQ-018 SHALL complete an accepted operation even if its request drops mid-operation; address wraps modulo 2^WORD_W.
REQ-019 SHALL never assert mem_ren and mem_wen together, nor sLoad_hit and sStore_hit together.

Reset
REQ-020 SHALL on nRST=0 immediately enter IDLE, clear word/row counters and latches, and drive all outputs to 0, including mid-operation (aborted operation produces no hit).

Configuration
REQ-021 SHALL, when macro SP_ARB_LOAD_FIRST_EN is defined, give sLoad priority over sStore in IDLE; without it, sStore wins (REQ-009); all other behaviour identical.

Verification
REQ-022 Load, load_addr=0x100, zero-wait memory, accept T0 -> reads 0x100..0x11C T1..T8, sLoad_hit at T3,T5,T7,T9 with sLoad_row 0,1,2,3, DONE at T9, IDLE at T10.
REQ-023 Store, store_addr=0x200, store_data=0xAAAABBBB_CCCCDDDD -> T1 write 0xCCCCDDDD@0x200, T2 write 0xAAAABBBB@0x204, sStore_hit T3 only.
REQ-024 sLoad and sStore together in IDLE -> store serviced first (load first with SP_ARB_LOAD_FIRST_EN); the other is accepted after DONE if still held.
REQ-025 mem_ready held 0 for 3 cycles on word 1 of row 0 -> mem_addr=0x104 held, row-0 hit delayed 3 cycles, data 0x{word@0x104,word@0x100} correct.
REQ-026 nRST pulsed low after row 1 hit -> all outputs 0 asynchronously, no further hits, new load after reset starts at row 0.
